// File: rtl/ultrasonic_burst_gen_pkg.sv
// Shared definitions for the ultrasonic burst generator: FSM state encodings
// and the default counter width.
package ultrasonic_defs;

    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/ultrasonic_burst_gen.sv
// Burst generator for an ultrasonic transducer: N complementary square-wave cycles
// per burst, then a gap, one-shot or continuous. Optional dead time: ULTRASONIC_DEADTIME_EN.
module ultrasonic_burst_gen
    import ultrasonic_defs::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned DEAD_CLKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic [CNT_W-1:0] gap_ticks,
    input  logic             continuous,
    output logic             drv_p,
    output logic             drv_n,
    output logic             busy,
    output logic             done
);

    if (DEAD_CLKS < 1) begin : g_dead_chk
        $error("DEAD_CLKS must be at least 1");
    end

    state_t           state, state_n;
    logic             phase, phase_n;
    logic [CNT_W-1:0] cyc_ctr, cyc_ctr_n;
    logic [CNT_W-1:0] gap_ctr, gap_ctr_n;
    logic [CNT_W-1:0] n_lat, n_lat_n;
    logic [CNT_W-1:0] g_lat, g_lat_n;
    logic             cont_lat, cont_lat_n;
    logic             gap_leave;
    logic             done_n, busy_n, drv_p_n, drv_n_n;
    logic             drv_gate_c;

    // Next-state and counter logic; en low overrides everything else.
    always_comb begin
        state_n    = state;
        phase_n    = phase;
        cyc_ctr_n  = cyc_ctr;
        gap_ctr_n  = gap_ctr;
        n_lat_n    = n_lat;
        g_lat_n    = g_lat;
        cont_lat_n = cont_lat;
        gap_leave  = 1'b0;
        done_n     = 1'b0;
        if (!en) begin
            state_n   = ST_IDLE;
            phase_n   = 1'b0;
            cyc_ctr_n = '0;
            gap_ctr_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (num_cycles != '0)) begin
                        n_lat_n    = num_cycles;
                        g_lat_n    = gap_ticks;
                        cont_lat_n = continuous;
                        phase_n    = 1'b0;
                        cyc_ctr_n  = '0;
                        gap_ctr_n  = '0;
                        state_n    = ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (tick) begin
                        phase_n = ~phase;
                        if (phase) begin
                            if (cyc_ctr == n_lat - CNT_W'(1)) begin
                                state_n   = ST_GAP;
                                gap_ctr_n = '0;
                            end else begin
                                cyc_ctr_n = cyc_ctr + CNT_W'(1);
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (g_lat == '0) begin
                        gap_leave = 1'b1;
                    end else if (tick) begin
                        if (gap_ctr == g_lat - CNT_W'(1)) begin
                            gap_leave = 1'b1;
                        end else begin
                            gap_ctr_n = gap_ctr + CNT_W'(1);
                        end
                    end
                    if (gap_leave) begin
                        phase_n   = 1'b0;
                        cyc_ctr_n = '0;
                        gap_ctr_n = '0;
                        if (cont_lat) begin
                            state_n = ST_BURST;
                        end else begin
                            state_n = ST_IDLE;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

`ifdef ULTRASONIC_DEADTIME_EN
    localparam int unsigned DEAD_W = $clog2(DEAD_CLKS + 1);

    logic [DEAD_W-1:0] dead_ctr, dead_ctr_n;

    // Reload the dead-time counter whenever a new half-period begins.
    always_comb begin
        dead_ctr_n = '0;
        if (state_n == ST_BURST) begin
            if ((state != ST_BURST) || (phase_n != phase)) begin
                dead_ctr_n = DEAD_W'(DEAD_CLKS);
            end else if (dead_ctr != '0) begin
                dead_ctr_n = dead_ctr - DEAD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dead_ctr <= '0;
        end else begin
            dead_ctr <= dead_ctr_n;
        end
    end

    assign drv_gate_c = (dead_ctr_n == '0);
`else
    assign drv_gate_c = 1'b1;
`endif

    // Output values for the next edge, derived from the next state.
    always_comb begin
        busy_n  = (state_n != ST_IDLE);
        drv_p_n = (state_n == ST_BURST) && !phase_n && drv_gate_c;
        drv_n_n = (state_n == ST_BURST) &&  phase_n && drv_gate_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            phase    <= 1'b0;
            cyc_ctr  <= '0;
            gap_ctr  <= '0;
            n_lat    <= '0;
            g_lat    <= '0;
            cont_lat <= 1'b0;
            drv_p    <= 1'b0;
            drv_n    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            cyc_ctr  <= cyc_ctr_n;
            gap_ctr  <= gap_ctr_n;
            n_lat    <= n_lat_n;
            g_lat    <= g_lat_n;
            cont_lat <= cont_lat_n;
            drv_p    <= drv_p_n;
            drv_n    <= drv_n_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_ultrasonic_burst_gen.sv
// Scoreboard bench for ultrasonic_burst_gen: expected {drv_p,drv_n,busy,done}
// per clock is queued when stimulus is driven and compared on each falling edge.
module tb_ultrasonic_burst_gen;

    localparam int unsigned CNT_W    = 16;
    localparam int          TICK_PER = 4;

    localparam logic [3:0] E_IDLE = 4'b0000;
    localparam logic [3:0] E_P    = 4'b1010;
    localparam logic [3:0] E_N    = 4'b0110;
    localparam logic [3:0] E_GAP  = 4'b0010;
    localparam logic [3:0] E_DONE = 4'b0001;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tick = 1'b0;
    logic             en = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_cycles = '0;
    logic [CNT_W-1:0] gap_ticks = '0;
    logic             continuous = 1'b0;
    logic             drv_p, drv_n, busy, done;

    int         n_checks = 0;
    int         n_errors = 0;
    int         tick_cnt = 0;
    string      scen = "reset";
    logic [3:0] exp_q[$];

    ultrasonic_burst_gen #(.CNT_W(CNT_W), .DEAD_CLKS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .en         (en),
        .start      (start),
        .num_cycles (num_cycles),
        .gap_ticks  (gap_ticks),
        .continuous (continuous),
        .drv_p      (drv_p),
        .drv_n      (drv_n),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            check({scen, "/outs"}, 32'({drv_p, drv_n, busy, done}), 32'(e));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        tick_cnt = (tick_cnt + 1) % TICK_PER;
        tick = (tick_cnt == 0);
    endtask

    task automatic push(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic align();
        for (int i = 0; i < 4 * TICK_PER && !tick; i++) cyc();
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) cyc();
        check({scen, "/drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc();
        cyc();
        push(E_IDLE, 4);
        drain();
        cyc();
        rst = 1'b0;
        en  = 1'b1;
        cyc();
        cyc();

        // One-shot N=3, G=2
        scen = "oneshot";
        align();
        start = 1'b1; num_cycles = 16'd3; gap_ticks = 16'd2; continuous = 1'b0;
        push(E_IDLE, 1);
        for (int c = 0; c < 3; c++) begin
            push(E_P, 4);
            push(E_N, 4);
        end
        push(E_GAP, 8);
        push(E_DONE, 1);
        push(E_IDLE, 4);
        cyc();
        start = 1'b0;
        drain();

        // Continuous N=2, G=1, en dropped after 60 clks
        scen = "continuous";
        align();
        start = 1'b1; num_cycles = 16'd2; gap_ticks = 16'd1; continuous = 1'b1;
        push(E_IDLE, 1);
        for (int k = 0; k < 60; k++) begin
            int m;
            m = k % 20;
            if (m < 16) push((((m / 4) % 2) == 0) ? E_P : E_N, 1);
            else        push(E_GAP, 1);
        end
        push(E_IDLE, 6);
        cyc();
        start = 1'b0; continuous = 1'b0;
        for (int i = 0; i < 59; i++) cyc();
        en = 1'b0;
        cyc();
        en = 1'b1;
        drain();

        // Zero-cycle start is ignored
        scen = "zero_n";
        start = 1'b1; num_cycles = 16'd0; gap_ticks = 16'd3;
        push(E_IDLE, 6);
        cyc();
        start = 1'b0;
        drain();

        // Restart mid-burst ignored; G=0 leaves gap after one clk
        scen = "restart";
        align();
        start = 1'b1; num_cycles = 16'd2; gap_ticks = 16'd0;
        push(E_IDLE, 1);
        for (int c = 0; c < 2; c++) begin
            push(E_P, 4);
            push(E_N, 4);
        end
        push(E_GAP, 1);
        push(E_DONE, 1);
        push(E_IDLE, 4);
        cyc();
        start = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        start = 1'b1; num_cycles = 16'd5; gap_ticks = 16'd7;
        cyc();
        start = 1'b0;
        drain();

        // Reset mid-burst
        scen = "rst_mid";
        align();
        start = 1'b1; num_cycles = 16'd3; gap_ticks = 16'd2;
        push(E_IDLE, 1);
        push(E_P, 4);
        push(E_N, 1);
        push(E_IDLE, 6);
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ultrasonic_burst_gen.md
Name: ultrasonic_burst_gen

Overview:
- Consumes the single-cycle `tick` strobe from the upstream clock divider.
- Produces complementary drive signals for the ultrasonic transducer as bursts of N full square-wave cycles, separated by a programmable gap.
- Runs either one-shot or continuously.
- Sits between the divider and the transducer driver pins.

Parameters:
- CNT_W, 16, width of cycle/gap counters and their config inputs.
- DEAD_CLKS, 2, clk cycles of dead time per edge (used only when ULTRASONIC_DEADTIME_EN is defined); min 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-clk strobe from the divider; one tick = one half-period of the output.
- en  in  1  global enable; low aborts any activity.
- start  in  1  one-clk request to begin a burst sequence.
- num_cycles  in  CNT_W  full output cycles per burst; latched at start.
- gap_ticks  in  CNT_W  ticks of silence after each burst; latched at start.
- continuous  in  1  repeat burst+gap until en falls; latched at start.
- drv_p  out  1  positive-phase drive.
- drv_n  out  1  negative-phase drive.
- busy  out  1  high in BURST or GAP.
- done  out  1  one-clk pulse when a one-shot sequence completes.

Behaviour:
- Reset: state=IDLE; all counters 0; drv_p=drv_n=busy=done=0. All outputs are registered.
- IDLE:
  - Outputs low.
  - start && en && num_cycles!=0: latch num_cycles/gap_ticks/continuous, phase=0, cyc_ctr=0, go to BURST. drv_p=1 on the next edge (1-clk latency from start).
  - start with num_cycles==0: ignored, no done.
- BURST:
  - drv_p = (phase==0), drv_n = (phase==1); never both high.
  - On tick, phase toggles.
  - On a tick where phase goes 1→0: if cyc_ctr==N-1, go to GAP with gap_ctr=0; else cyc_ctr++.
  - A tick in the same cycle as the accepted start is ignored; the first half-period counts from the next tick.
- GAP:
  - Outputs low.
  - gap_ticks==0: leave GAP on the next clk.
  - Otherwise, on tick: if gap_ctr==G-1, leave GAP; else gap_ctr++.
  - Leaving GAP with continuous: go to BURST, phase=0, cyc_ctr=0 (no done).
  - Leaving GAP with one-shot: go to IDLE, done=1 for exactly one clk.
- Abort: en low in any state → IDLE on the next edge. Outputs low, counters cleared, no done. en low has priority over tick and start in the same cycle.
- start while busy is ignored; latched config is not updated mid-sequence.
- rst mid-burst: outputs low on the next edge, no done.
- Counter arithmetic is unsigned CNT_W. N and G are at most 2^CNT_W-1, so no wrap.

Optional Feature:
- Macro ULTRASONIC_DEADTIME_EN.
- Defined: at each phase toggle in BURST, both drv_p and drv_n are held low for DEAD_CLKS clks before the new phase asserts.
  - The same low interval applies on entering BURST from IDLE/GAP.
  - Tick counting is unaffected; dead time is carved out of the new half-period.
  - Requires tick period > DEAD_CLKS.
- Undefined: drv_n == ~drv_p throughout BURST with zero dead time; DEAD_CLKS is unused.

Decomposition:
- Shared header/package `ultrasonic_defs`: state encodings (ST_IDLE=2'd0, ST_BURST=2'd1, ST_GAP=2'd2) and the default CNT_W.
- No sub-module: the FSM and two counters stay in one file.
- The top level instantiates the divider and wires its div_clk to tick.

Test Plan:
- tick every 4 clks, N=3, G=2, one-shot → drv_p high 4 / low 4 clks (drv_n inverse), 3 times; then 8 clks both low; done pulses once; busy falls the same cycle done rises.
- continuous=1, N=2, G=1, en held 60 clks then dropped → repeated 2-cycle bursts with 4-clk gaps; on the en fall, outputs low next edge, busy=0, no done.
- start with num_cycles=0 → no state change, busy=0, done=0.
- start asserted again mid-burst with different N → ignored; original N completes.
- rst asserted mid-BURST → next edge: drv_p=drv_n=busy=done=0, state IDLE.
- With ULTRASONIC_DEADTIME_EN, DEAD_CLKS=2, tick every 8 clks → at each toggle both drives low for exactly 2 clks; the assertion drv_p&drv_n never fires.
